// File: rtl/imem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_ctrl_pkg
// Description : Shared definitions for the instruction-memory load controller.
//               Holds the controller state encoding and the default
//               instruction word / address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_ctrl_pkg;

    localparam int c_INST_W = 32;   // default instruction word width
    localparam int c_INST_A = 8;    // default word-address width

    // Controller states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_VFY_ACC = 3'd2,
        ST_VFY_RD  = 3'd3,
        ST_VFY_CMP = 3'd4,
        ST_RUN     = 3'd5
    } imem_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : imem_addr_ctr
// Description : Saturating word-address counter. Clear has priority over
//               increment; once the counter reaches its all-ones value it
//               holds there, so the address never wraps.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               i_clr       - return to address 0
//               i_inc       - advance by one (ignored at maximum)
//               o_addr      - current address
//               o_at_max    - address equals 2^ADDR_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module imem_addr_ctr
    import imem_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_INST_A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_at_max
);

    localparam logic [ADDR_W-1:0] c_MAX = '1;

    logic [ADDR_W-1:0] r_addr;
    logic              w_at_max;

    assign w_at_max = (r_addr == c_MAX);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_addr <= '0;
        end else if (i_inc && !w_at_max) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr   = r_addr;
    assign o_at_max = w_at_max;

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Host-side controller for the instruction memory. Programs the
//               memory from a host word stream, reads it back and compares it
//               against a second stream, and gates the core fetch stage.
// Ports       : clk, reset                  - clock, sync active-high reset
//               start_load/start_verify     - stream requests (IDLE only)
//               run_req/stop_req            - release / halt core fetch
//               host_valid/data/last, host_ready - host word handshake
//               exp_address/data/MW/MR, exp_out - memory export port
//               core_run                    - fetch enable, high in RUN
//               done                        - end-of-stream pulse
//               error/err_addr              - sticky first verify mismatch
//               word_count                  - words processed by last stream
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int INST_W = c_INST_W,
    parameter int INST_A = c_INST_A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_load,
    input  logic              start_verify,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              host_valid,
    input  logic [INST_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic [INST_A-1:0] exp_address,
    output logic [INST_W-1:0] exp_data,
    output logic              exp_MW,
    output logic              exp_MR,
    input  logic [INST_W-1:0] exp_out,
    output logic              core_run,
    output logic              done,
    output logic              error,
    output logic [INST_A-1:0] err_addr,
    output logic [INST_A:0]   word_count
);

    imem_state_e       r_state;
    logic [INST_A-1:0] r_exp_addr;
    logic [INST_W-1:0] r_exp_data;
    logic [INST_W-1:0] r_expected;
    logic              r_last;
    logic              r_mw;
    logic              r_mr;
    logic              r_done;
    logic              r_error;
    logic [INST_A-1:0] r_err_addr;
    logic [INST_A:0]   r_word_count;

    logic              w_hs;
    logic              w_clr;
    logic              w_inc;
    logic [INST_A-1:0] w_addr;
    logic              w_at_max;

    assign host_ready = (r_state == ST_LOAD) || (r_state == ST_VFY_ACC);
    assign w_hs       = host_valid && host_ready;

    // A new stream always starts at address 0; load takes priority but both
    // clear the same way.
    assign w_clr = (r_state == ST_IDLE) && (start_load || start_verify);
    assign w_inc = ((r_state == ST_LOAD) && w_hs) || (r_state == ST_VFY_CMP);

    imem_addr_ctr #(
        .ADDR_W (INST_A)
    ) u_addr_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .o_addr   (w_addr),
        .o_at_max (w_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_exp_addr   <= '0;
            r_exp_data   <= '0;
            r_expected   <= '0;
            r_last       <= 1'b0;
            r_mw         <= 1'b0;
            r_mr         <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_addr   <= '0;
            r_word_count <= '0;
        end else begin
            // Strobes and done are single-cycle unless re-armed below.
            r_mw   <= 1'b0;
            r_mr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_load) begin
                        r_state      <= ST_LOAD;
                        r_word_count <= '0;
                    end else if (start_verify) begin
                        r_state      <= ST_VFY_ACC;
                        r_word_count <= '0;
                        r_error      <= 1'b0;
                        r_err_addr   <= '0;
                    end else if (run_req) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        // Write is driven the cycle after the handshake. On the
                        // final word the FSM is already back in IDLE while the
                        // write and done are presented, so no extra word is
                        // accepted.
                        r_mw         <= 1'b1;
                        r_exp_addr   <= w_addr;
                        r_exp_data   <= host_data;
                        r_word_count <= r_word_count + 1'b1;
                        if (host_last || w_at_max) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_VFY_ACC: begin
                    if (w_hs) begin
                        r_expected <= host_data;
                        r_last     <= host_last;
                        r_mr       <= 1'b1;
                        r_exp_addr <= w_addr;
                        r_state    <= ST_VFY_RD;
                    end
                end
                ST_VFY_RD: begin
                    // Memory returns read data during the following cycle.
                    r_state <= ST_VFY_CMP;
                end
                ST_VFY_CMP: begin
                    if ((exp_out != r_expected) && !r_error) begin
                        r_error    <= 1'b1;
                        r_err_addr <= w_addr;
                    end
                    r_word_count <= r_word_count + 1'b1;
                    if (r_last || w_at_max) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_VFY_ACC;
                    end
                end
                ST_RUN: begin
                    if (stop_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign exp_address = r_exp_addr;
    assign exp_data    = r_exp_data;
    assign exp_MW      = r_mw;
    assign exp_MR      = r_mr;
    assign core_run    = (r_state == ST_RUN);
    assign done        = r_done;
    assign error       = r_error;
    assign err_addr    = r_err_addr;
    assign word_count  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_load_ctrl
// Description : Directed self-checking bench for imem_load_ctrl. Instance A
//               uses default widths with a behavioural memory on its export
//               port; instance B uses a 2-bit address for saturation cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: INST_W=32, INST_A=8
    logic        sl_a, sv_a, run_a, stop_a, hv_a, hl_a, hr_a;
    logic [31:0] hd_a, wd_a, eo_a;
    logic [7:0]  addr_a, erra_a;
    logic        mw_a, mr_a, core_a, done_a, err_a;
    logic [8:0]  wc_a;

    // Instance B: INST_W=32, INST_A=2
    logic        sl_b, sv_b, run_b, stop_b, hv_b, hl_b, hr_b;
    logic [31:0] hd_b, wd_b, eo_b;
    logic [1:0]  addr_b, erra_b;
    logic        mw_b, mr_b, core_b, done_b, err_b;
    logic [2:0]  wc_b;

    imem_load_ctrl #(.INST_W(32), .INST_A(8)) u_dut_a (
        .clk(clk), .reset(reset), .start_load(sl_a), .start_verify(sv_a),
        .run_req(run_a), .stop_req(stop_a), .host_valid(hv_a), .host_data(hd_a),
        .host_last(hl_a), .host_ready(hr_a), .exp_address(addr_a), .exp_data(wd_a),
        .exp_MW(mw_a), .exp_MR(mr_a), .exp_out(eo_a), .core_run(core_a),
        .done(done_a), .error(err_a), .err_addr(erra_a), .word_count(wc_a)
    );

    imem_load_ctrl #(.INST_W(32), .INST_A(2)) u_dut_b (
        .clk(clk), .reset(reset), .start_load(sl_b), .start_verify(sv_b),
        .run_req(run_b), .stop_req(stop_b), .host_valid(hv_b), .host_data(hd_b),
        .host_last(hl_b), .host_ready(hr_b), .exp_address(addr_b), .exp_data(wd_b),
        .exp_MW(mw_b), .exp_MR(mr_b), .exp_out(eo_b), .core_run(core_b),
        .done(done_b), .error(err_b), .err_addr(erra_b), .word_count(wc_b)
    );

    // Behavioural memory behind instance A: one-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mw_a) mem[addr_a] <= wd_a;
        if (mr_a) eo_a <= mem[addr_a];
    end
    assign eo_b = 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({hr_a, mw_a, mr_a, core_a, done_a, err_a} !== 6'b0) begin failures++;
            $display("FAIL reset_a_flags got=%b want=000000", {hr_a, mw_a, mr_a, core_a, done_a, err_a}); end
        checks++; if ({addr_a, wd_a, erra_a, wc_a} !== 57'h0) begin failures++;
            $display("FAIL reset_a_buses got=%h want=0", {addr_a, wd_a, erra_a, wc_a}); end
        checks++; if ({hr_b, mw_b, mr_b, core_b, done_b, err_b, addr_b, erra_b, wc_b} !== 13'h0) begin failures++;
            $display("FAIL reset_b got=%h want=0", {hr_b, mw_b, mr_b, core_b, done_b, err_b, addr_b, erra_b, wc_b}); end
    endtask

    task automatic test_load();
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        sl_a = 1'b1; step(); sl_a = 1'b0;
        checks++; if (hr_a !== 1'b1) begin failures++;
            $display("FAIL load_ready got=%b want=1", hr_a); end
        for (int i = 0; i < 4; i++) begin
            hv_a = 1'b1; hd_a = words[i]; hl_a = (i == 3);
            step();
            checks++; if ({mw_a, mr_a, addr_a, wd_a, done_a} !== {1'b1, 1'b0, i[7:0], words[i], (i == 3)}) begin failures++;
                $display("FAIL load_write%0d got mw=%b mr=%b a=%h d=%h done=%b want mw=1 mr=0 a=%0d d=%h done=%b",
                         i, mw_a, mr_a, addr_a, wd_a, done_a, i, words[i], (i == 3)); end
        end
        hv_a = 1'b0; hl_a = 1'b0;
        checks++; if (hr_a !== 1'b0) begin failures++;
            $display("FAIL load_ready_after got=%b want=0", hr_a); end
        step();
        checks++; if ({mw_a, done_a, wc_a} !== {1'b0, 1'b0, 9'd4}) begin failures++;
            $display("FAIL load_end got mw=%b done=%b wc=%0d want mw=0 done=0 wc=4", mw_a, done_a, wc_a); end
    endtask

    task automatic test_verify(input string name, input logic [31:0] w2, input logic [31:0] w3,
                               input logic exp_err, input logic [7:0] exp_ea);
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = w2; words[3] = w3;
        sv_a = 1'b1; step(); sv_a = 1'b0;
        checks++; if ({hr_a, err_a, erra_a} !== {1'b1, 1'b0, 8'h0}) begin failures++;
            $display("FAIL %s_enter got rdy=%b err=%b ea=%h want rdy=1 err=0 ea=0", name, hr_a, err_a, erra_a); end
        for (int i = 0; i < 4; i++) begin
            hv_a = 1'b1; hd_a = words[i]; hl_a = (i == 3);
            step();
            hv_a = 1'b0; hl_a = 1'b0;
            checks++; if ({mr_a, mw_a, hr_a, addr_a} !== {1'b1, 1'b0, 1'b0, i[7:0]}) begin failures++;
                $display("FAIL %s_read%0d got mr=%b mw=%b rdy=%b a=%h want mr=1 mw=0 rdy=0 a=%0d",
                         name, i, mr_a, mw_a, hr_a, addr_a, i); end
            step();
            checks++; if ({mr_a, done_a} !== 2'b00) begin failures++;
                $display("FAIL %s_cmp%0d got mr=%b done=%b want 0 0", name, i, mr_a, done_a); end
            step();
            checks++; if ({mr_a, done_a} !== {1'b0, (i == 3)}) begin failures++;
                $display("FAIL %s_next%0d got mr=%b done=%b want mr=0 done=%b", name, i, mr_a, done_a, (i == 3)); end
        end
        step();
        checks++; if ({done_a, hr_a, err_a, erra_a, wc_a} !== {1'b0, 1'b0, exp_err, exp_ea, 9'd4}) begin failures++;
            $display("FAIL %s_result got done=%b rdy=%b err=%b ea=%0d wc=%0d want done=0 rdy=0 err=%b ea=%0d wc=4",
                     name, done_a, hr_a, err_a, erra_a, wc_a, exp_err, exp_ea); end
    endtask

    task automatic test_saturate();
        sl_b = 1'b1; step(); sl_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hv_b = 1'b1; hd_b = 32'hA0 + i; hl_b = 1'b0;
            checks++; if (hr_b !== (i < 4)) begin failures++;
                $display("FAIL sat_ready%0d got=%b want=%b", i, hr_b, (i < 4)); end
            step();
            if (i < 4) begin
                checks++; if ({mw_b, addr_b, wd_b, done_b} !== {1'b1, i[1:0], 32'hA0 + i, (i == 3)}) begin failures++;
                    $display("FAIL sat_write%0d got mw=%b a=%0d d=%h done=%b want mw=1 a=%0d done=%b",
                             i, mw_b, addr_b, wd_b, done_b, i, (i == 3)); end
            end else begin
                checks++; if ({mw_b, done_b, hr_b, wc_b} !== {1'b0, 1'b0, 1'b0, 3'd4}) begin failures++;
                    $display("FAIL sat_extra got mw=%b done=%b rdy=%b wc=%0d want 0 0 0 4", mw_b, done_b, hr_b, wc_b); end
            end
        end
        hv_b = 1'b0;
    endtask

    task automatic test_run_priority();
        sl_a = 1'b1; run_a = 1'b1; step(); sl_a = 1'b0; run_a = 1'b0;
        checks++; if ({hr_a, core_a} !== 2'b10) begin failures++;
            $display("FAIL prio_enter got rdy=%b run=%b want rdy=1 run=0", hr_a, core_a); end
        hv_a = 1'b1; hd_a = 32'h11; hl_a = 1'b1; step(); hv_a = 1'b0; hl_a = 1'b0;
        checks++; if ({mw_a, done_a, core_a, hr_a} !== 4'b1100) begin failures++;
            $display("FAIL prio_load got mw=%b done=%b run=%b rdy=%b want 1 1 0 0", mw_a, done_a, core_a, hr_a); end
        run_a = 1'b1; step(); run_a = 1'b0;
        checks++; if ({core_a, mw_a, mr_a, hr_a} !== 4'b1000) begin failures++;
            $display("FAIL run_enter got run=%b mw=%b mr=%b rdy=%b want 1 0 0 0", core_a, mw_a, mr_a, hr_a); end
        sl_a = 1'b1; step(); sv_a = 1'b1; step(); sl_a = 1'b0; sv_a = 1'b0;
        checks++; if ({core_a, hr_a, mr_a} !== 3'b100) begin failures++;
            $display("FAIL run_ignore got run=%b rdy=%b mr=%b want 1 0 0", core_a, hr_a, mr_a); end
        stop_a = 1'b1; step(); stop_a = 1'b0;
        checks++; if ({core_a, hr_a} !== 2'b00) begin failures++;
            $display("FAIL run_stop got run=%b rdy=%b want 0 0", core_a, hr_a); end
        step();
        checks++; if ({core_a, hr_a} !== 2'b00) begin failures++;
            $display("FAIL run_not_queued got run=%b rdy=%b want 0 0", core_a, hr_a); end
    endtask

    task automatic test_reset_midload();
        sl_a = 1'b1; step(); sl_a = 1'b0;
        hv_a = 1'b1; hd_a = 32'h11; step();
        hd_a = 32'h22; step();
        checks++; if ({mw_a, addr_a, wc_a} !== {1'b1, 8'd1, 9'd2}) begin failures++;
            $display("FAIL mid_pre got mw=%b a=%0d wc=%0d want 1 1 2", mw_a, addr_a, wc_a); end
        hd_a = 32'h33; reset = 1'b1; step(); reset = 1'b0; hv_a = 1'b0;
        checks++; if ({hr_a, mw_a, mr_a, core_a, done_a, err_a} !== 6'b0) begin failures++;
            $display("FAIL mid_flags got=%b want=000000", {hr_a, mw_a, mr_a, core_a, done_a, err_a}); end
        checks++; if ({addr_a, wd_a, erra_a, wc_a} !== 57'h0) begin failures++;
            $display("FAIL mid_buses got=%h want=0", {addr_a, wd_a, erra_a, wc_a}); end
        sl_a = 1'b1; step(); sl_a = 1'b0;
        hv_a = 1'b1; hd_a = 32'h11; hl_a = 1'b1; step(); hv_a = 1'b0; hl_a = 1'b0;
        checks++; if ({mw_a, addr_a, wd_a, done_a} !== {1'b1, 8'd0, 32'h11, 1'b1}) begin failures++;
            $display("FAIL mid_restart got mw=%b a=%0d d=%h done=%b want 1 0 11 1", mw_a, addr_a, wd_a, done_a); end
        step();
        checks++; if (wc_a !== 9'd1) begin failures++;
            $display("FAIL mid_count got=%0d want=1", wc_a); end
    endtask

    initial begin
        reset = 1'b1;
        {sl_a, sv_a, run_a, stop_a, hv_a, hl_a} = '0; hd_a = '0;
        {sl_b, sv_b, run_b, stop_b, hv_b, hl_b} = '0; hd_b = '0;
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_load();
        test_verify("vfy_ok", 32'h33, 32'h44, 1'b0, 8'd0);
        test_verify("vfy_bad", 32'hFF, 32'h44, 1'b1, 8'd2);
        test_verify("vfy_clear", 32'h33, 32'h44, 1'b0, 8'd0);
        test_verify("vfy_sticky", 32'hFF, 32'hEE, 1'b1, 8'd2);
        test_reset_midload();
        test_saturate();
        test_run_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
